// File: rtl/regfile_decoded.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_decoded
//  Description : 32 x WIDTH general-purpose register file. One synchronous
//                write port gated by a 5-to-32 one-hot select, two
//                combinational read ports, register 0 hardwired to zero,
//                optional same-cycle write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_decoded #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  input  logic [WIDTH-1:0] data_writeReg,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  // Read view of the whole file; entry 0 is a constant zero, not storage.
  logic [31:0][WIDTH-1:0] reg_view;

  assign reg_view[0] = '0;

  // Registers 1..31: each has its own decoded select and enabled flop.
  for (genvar i = 1; i < 32; i++) begin : g_reg
    logic             sel;
    logic             wr_en;
    logic [WIDTH-1:0] q;

    assign sel   = (ctrl_writeReg == 5'(i));
    assign wr_en = sel & ctrl_writeEnable & ~ctrl_reset;

    // Synchronous clear has priority; otherwise load only when selected.
    always_ff @(posedge clock) begin
      if (ctrl_reset) begin
        q <= '0;
      end else if (wr_en) begin
        q <= data_writeReg;
      end
    end

    assign reg_view[i] = q;
  end

  // Forwarding is qualified exactly like a real write, so a write to r0
  // or one that coincides with reset never leaks onto the read ports.
  logic write_live;
  logic fwd_a;
  logic fwd_b;

  assign write_live = ctrl_writeEnable & ~ctrl_reset & (ctrl_writeReg != 5'd0);
  assign fwd_a      = BYPASS & write_live & (ctrl_writeReg == ctrl_readRegA);
  assign fwd_b      = BYPASS & write_live & (ctrl_writeReg == ctrl_readRegB);

  // Combinational 32:1 read muxes with optional forwarding override.
  always_comb begin
    data_readRegA = reg_view[ctrl_readRegA];
    data_readRegB = reg_view[ctrl_readRegB];
    if (fwd_a) begin
      data_readRegA = data_writeReg;
    end
    if (fwd_b) begin
      data_readRegB = data_writeReg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_decoded.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_decoded
//  Description : Directed self-checking bench for regfile_decoded. Drives
//                one BYPASS=0 and one BYPASS=1 instance from shared inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_decoded;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] a0, b0, a1, b1;

  int checks = 0;
  int errors = 0;

  regfile_decoded #(.WIDTH(32), .BYPASS(1'b0)) dut_nb (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (a0),
    .data_readRegB    (b0)
  );

  regfile_decoded #(.WIDTH(32), .BYPASS(1'b1)) dut_bp (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (a1),
    .data_readRegB    (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present a write for one edge, then drop the strobe.
  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = idx;
    data_writeReg    = val;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
  endtask

  // Set both read indices and check all four outputs against one value each.
  task automatic read_chk(input string tag, input logic [4:0] ia, input logic [4:0] ib,
                          input logic [31:0] ea, input logic [31:0] eb);
    ctrl_readRegA = ia;
    ctrl_readRegB = ib;
    #1;
    check_eq({tag, "_nbA"}, a0, ea);
    check_eq({tag, "_nbB"}, b0, eb);
    check_eq({tag, "_bpA"}, a1, ea);
    check_eq({tag, "_bpB"}, b1, eb);
  endtask

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    data_writeReg    = 32'h0;
    @(posedge clock);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;

    // Reset state: every index reads zero.
    for (int i = 0; i < 32; i++) begin
      read_chk("rst_state", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // Reset clears a written register.
    write_reg(5'd5, 32'hDEADBEEF);
    read_chk("pre_rst_r5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    ctrl_reset = 1'b1;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    read_chk("rst_clear", 5'd5, 5'd0, 32'h0, 32'h0);

    // Fill r1..r31, then read back every index on both ports.
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'h1000_0000 + 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] ea;
      logic [31:0] eb;
      int          j;
      j  = (i + 7) % 32;
      ea = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      eb = (j == 0) ? 32'h0 : 32'h1000_0000 + 32'(j);
      read_chk("fill", 5'(i), 5'(j), ea, eb);
    end

    // Write to r0 is discarded and disturbs nothing.
    write_reg(5'd0, 32'hFFFFFFFF);
    read_chk("r0_immune", 5'd0, 5'd1, 32'h0, 32'h1000_0001);

    // Enable low holds the addressed register.
    write_reg(5'd7, 32'h12345678);
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'hAAAAAAAA;
    @(posedge clock);
    #1;
    read_chk("en_low", 5'd7, 5'd7, 32'h12345678, 32'h12345678);

    // Read-during-write on r9 with both ports aimed at it.
    write_reg(5'd9, 32'h11111111);
    ctrl_readRegA    = 5'd9;
    ctrl_readRegB    = 5'd9;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h22222222;
    #1;
    check_eq("rdw_nbA_old", a0, 32'h11111111);
    check_eq("rdw_nbB_old", b0, 32'h11111111);
    check_eq("rdw_bpA_fwd", a1, 32'h22222222);
    check_eq("rdw_bpB_fwd", b1, 32'h22222222);
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    read_chk("rdw_after", 5'd9, 5'd9, 32'h22222222, 32'h22222222);

    // Forwarding is per-port: only B matches the write index.
    ctrl_readRegA    = 5'd4;
    ctrl_readRegB    = 5'd6;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd6;
    data_writeReg    = 32'h0BADCAFE;
    #1;
    check_eq("fwd_sel_bpA", a1, 32'h1000_0004);
    check_eq("fwd_sel_bpB", b1, 32'h0BADCAFE);
    check_eq("fwd_sel_nbB", b0, 32'h1000_0006);
    // A write to r0 must never be forwarded.
    ctrl_writeReg = 5'd0;
    ctrl_readRegB = 5'd0;
    #1;
    check_eq("fwd_r0_bpB", b1, 32'h0);
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    read_chk("fwd_commit", 5'd6, 5'd0, 32'h1000_0006, 32'h0);

    // Reset beats a simultaneous write to r3; no forwarding while in reset.
    ctrl_readRegA    = 5'd3;
    ctrl_readRegB    = 5'd3;
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'hCAFEF00D;
    #1;
    check_eq("rst_wr_nbA", a0, 32'h1000_0003);
    check_eq("rst_wr_bpA", a1, 32'h1000_0003);
    check_eq("rst_wr_bpB", b1, 32'h1000_0003);
    @(posedge clock);
    #1;
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    read_chk("rst_wr_after", 5'd3, 5'd9, 32'h0, 32'h0);

    // Writes resume on the first edge with reset low.
    write_reg(5'd3, 32'h5A5AA5A5);
    read_chk("resume", 5'd3, 5'd31, 32'h5A5AA5A5, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
32-entry general-purpose register file for the processor datapath. It sits directly downstream of the 5-to-32 one-hot write-select decoder. One synchronous write port is gated by the decoded select lines, and two combinational read ports feed the ALU operand muxes. Register 0 is hardwired to zero.

Parameters:
WIDTH, 32, data width of each register and of all data ports
BYPASS, 0, 1 = same-cycle write-to-read forwarding on both read ports; 0 = reads return stored contents only

Ports:
clock  input  1  system clock; all state updates on its rising edge
ctrl_reset  input  1  synchronous, active-high reset
ctrl_writeEnable  input  1  write strobe for the current cycle
ctrl_writeReg  input  5  destination register index
ctrl_readRegA  input  5  read port A index
ctrl_readRegB  input  5  read port B index
data_writeReg  input  WIDTH  write data
data_readRegA  output  WIDTH  read port A data
data_readRegB  output  WIDTH  read port B data

Behaviour:
- Clocking and reset:
  - One clock, `clock`.
  - `ctrl_reset` is synchronous and active-high, sampled on the rising edge of `clock`.
  - Reset clears registers 1..31 to 0 on the edge where it is sampled high.
  - There is no asynchronous path.
- Write path:
  - `ctrl_writeReg` is decoded 5-to-32 one-hot (bit i high iff index == i).
  - Per-register enable for register i = onehot[i] AND `ctrl_writeEnable` AND NOT `ctrl_reset`, for i = 1..31.
  - On the rising edge, an enabled register loads `data_writeReg`. All other registers hold.
- Register 0:
  - Has no storage element; it always reads 0.
  - A write to index 0 is silently discarded. No side effect on any other register.
- Read path:
  - Fully combinational, zero-cycle latency.
  - `data_readRegX` = contents of the register at `ctrl_readRegX`, or 0 when the index is 0.
- Simultaneous reads: A and B may address the same register and both return identical data.
- Read-during-write, BYPASS = 0:
  - The read returns the old value during the write cycle.
  - The new value is visible from the cycle after the edge.
- Read-during-write, BYPASS = 1:
  - Forwarding applies when `ctrl_writeEnable` = 1, `ctrl_reset` = 0, `ctrl_writeReg` != 0 and `ctrl_writeReg` == `ctrl_readRegX`.
  - When it applies, `data_readRegX` = `data_writeReg` in the same cycle.
  - It applies independently to A and B.
- Reset vs write on the same edge: reset wins. The target register ends at 0, and bypass is suppressed while reset is high.
- Reset mid-operation: any write presented on a reset edge is lost. Writes resume normally on the first edge with `ctrl_reset` low.
- Output values:
  - After reset, both outputs read 0 for every index until a write occurs.
  - Before the first reset, register contents are undefined. The bench must not check them.
- Enable low: no register changes regardless of `ctrl_writeReg` and `data_writeReg`.
- Width: data is stored and returned unmodified. No sign extension or truncation.
- Structure:
  - Storage is 31 WIDTH-bit enabled flops.
  - Read ports are 32:1 muxes, or tri-state equivalents driven by the decoded read indices.
  - Target is 120–400 lines RTL including the decode.

Test Plan:
- Reset clears state:
  - Stimulus: write 0xDEADBEEF to r5, assert `ctrl_reset` for 1 cycle, then read r5 on A and r0 on B.
  - Required: both ports read 0x00000000.
- Basic write/read over all indices:
  - Stimulus: for i = 1..31, write 0x1000_0000+i to ri, then read every index on A and B.
  - Required: each ri returns 0x1000_0000+i; r0 returns 0.
- Register 0 immune:
  - Stimulus: write 0xFFFFFFFF to r0, then read r0 on A and r1 on B.
  - Required: r0 reads 0; r1 is unchanged.
- Enable low holds:
  - Stimulus: with r7 = 0x12345678, present ctrl_writeReg = 7, data = 0xAAAAAAAA, ctrl_writeEnable = 0.
  - Required: r7 still reads 0x12345678.
- Read-during-write:
  - Stimulus: with r9 = 0x11111111, write 0x22222222 to r9 while A = B = 9.
  - Required, BYPASS = 0: both read 0x11111111 in that cycle and 0x22222222 in the next.
  - Required, BYPASS = 1: both read 0x22222222 in the same cycle.
- Reset beats write:
  - Stimulus: on one edge assert `ctrl_reset` = 1 and `ctrl_writeEnable` = 1 with r3 target, data 0xCAFEF00D.
  - Required: r3 reads 0, and there is no bypass of 0xCAFEF00D in that cycle.
